// File: rtl/dbg_run_ctrl_pkg.sv
// Shared types and defaults for the hart-side debug run-control responder.
package dbg_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'b00,
        ST_HALTING  = 2'b01,
        ST_HALTED   = 2'b10,
        ST_RESUMING = 2'b11
    } run_state_e;

    localparam int unsigned DEFAULT_HALT_TIMEOUT = 1024;
    localparam int unsigned DEFAULT_CNT_W        = 16;

endpackage

// File: rtl/dbg_sat_counter.sv
// Saturating up-counter with a registered flag that rises on the same edge the count reaches limit.
module dbg_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != limit)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            at_limit <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_limit <= (count_d == limit);
        end
    end

endmodule

// File: rtl/dbg_hart_run_ctrl.sv
// Hart-side responder turning debug haltreq/resumereq levels into core commands and status.
module dbg_hart_run_ctrl
    import dbg_run_ctrl_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic haltreq_i,
    input  logic resumereq_i,
    input  logic core_halted_i,
    output logic hart_halt_o,
    output logic hart_resume_o,
    output logic halted_o,
    output logic running_o,
    output logic resumeack_o,
    output logic unavail_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(HALT_TIMEOUT);

    run_state_e state_q;
    run_state_e state_d;
    logic       halt_d;
    logic       resume_d;
    logic       resumeack_d;
    logic       cnt_clear;
    logic       cnt_enable;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        resumeack_d = resumeack_o;

        unique case (state_q)
            ST_RUNNING: begin
                // A core that entered debug on its own (ebreak) is reported at once.
                if (core_halted_i) begin
                    state_d = ST_HALTED;
                end else if (haltreq_i) begin
                    state_d = ST_HALTING;
                end
            end
            ST_HALTING: begin
                if (core_halted_i) begin
                    state_d = ST_HALTED;
                end else if (!haltreq_i) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_HALTED: begin
                if (resumereq_i && !haltreq_i) begin
                    state_d     = ST_RESUMING;
                    resumeack_d = 1'b0;
                end
            end
            ST_RESUMING: begin
                if (!core_halted_i) begin
                    state_d     = ST_RUNNING;
                    resumeack_d = 1'b1;
                end
            end
            default: state_d = ST_RUNNING;
        endcase

        // Halt command follows the state being entered so it lands one cycle after the request.
        unique case (state_d)
            ST_HALTING: halt_d = 1'b1;
            ST_HALTED:  halt_d = haltreq_i;
            default:    halt_d = 1'b0;
        endcase

        resume_d   = (state_q == ST_HALTED) && (state_d == ST_RESUMING);
        cnt_enable = (state_q == ST_HALTING);
        cnt_clear  = (state_q != ST_HALTING) || (state_d != ST_HALTING);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUNNING;
            hart_halt_o   <= 1'b0;
            hart_resume_o <= 1'b0;
            halted_o      <= 1'b0;
            running_o     <= 1'b1;
            resumeack_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hart_halt_o   <= halt_d;
            hart_resume_o <= resume_d;
            halted_o      <= (state_d == ST_HALTED) || (state_d == ST_RESUMING);
            running_o     <= (state_d == ST_RUNNING) || (state_d == ST_HALTING);
            resumeack_o   <= resumeack_d;
        end
    end

    // The counter's registered flag is the unavail status; it clears whenever HALTING is left.
    dbg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_halt_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .limit    (TIMEOUT_LIMIT),
        .at_limit (unavail_o)
    );

endmodule

// File: tb/tb_dbg_hart_run_ctrl.sv
// Scoreboard bench for dbg_hart_run_ctrl: a cycle model pushes expected outputs, the DUT result pops them.
module tb_dbg_hart_run_ctrl;

    localparam int T = 8;

    localparam int M_RUN      = 0;
    localparam int M_HALTING  = 1;
    localparam int M_HALTED   = 2;
    localparam int M_RESUMING = 3;

    logic clock = 1'b0;
    logic reset;
    logic haltreq_i;
    logic resumereq_i;
    logic core_halted_i;
    logic hart_halt_o;
    logic hart_resume_o;
    logic halted_o;
    logic running_o;
    logic resumeack_o;
    logic unavail_o;

    int checks = 0;
    int errors = 0;
    string phase = "init";
    logic [5:0] exp_q[$];

    int   m_st;
    int   m_cnt;
    logic m_halt, m_resume, m_halted, m_running, m_ack, m_unavail;

    always #5 clock = ~clock;

    dbg_hart_run_ctrl #(
        .HALT_TIMEOUT (T),
        .CNT_W        (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .haltreq_i     (haltreq_i),
        .resumereq_i   (resumereq_i),
        .core_halted_i (core_halted_i),
        .hart_halt_o   (hart_halt_o),
        .hart_resume_o (hart_resume_o),
        .halted_o      (halted_o),
        .running_o     (running_o),
        .resumeack_o   (resumeack_o),
        .unavail_o     (unavail_o)
    );

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b (halt,resume,halted,running,ack,unavail)",
                     tag, $time, obs, expv);
        end
    endtask

    // Reference behaviour for one rising edge with the given inputs.
    task automatic model_edge(input logic r, input logic h, input logic rs, input logic ch);
        m_resume = 1'b0;
        if (r) begin
            m_st = M_RUN; m_cnt = 0;
            m_halt = 1'b0; m_ack = 1'b0; m_unavail = 1'b0;
        end else begin
            case (m_st)
                M_RUN: begin
                    m_unavail = 1'b0;
                    if (ch) begin
                        m_st = M_HALTED; m_halt = h;
                    end else if (h) begin
                        m_st = M_HALTING; m_cnt = 0; m_halt = 1'b1;
                    end else begin
                        m_halt = 1'b0;
                    end
                end
                M_HALTING: begin
                    if (ch) begin
                        m_st = M_HALTED; m_cnt = 0; m_unavail = 1'b0; m_halt = h;
                    end else if (!h) begin
                        m_st = M_RUN; m_cnt = 0; m_unavail = 1'b0; m_halt = 1'b0;
                    end else begin
                        if (m_cnt < T) m_cnt++;
                        m_unavail = (m_cnt == T);
                        m_halt = 1'b1;
                    end
                end
                M_HALTED: begin
                    if (rs && !h) begin
                        m_st = M_RESUMING; m_resume = 1'b1; m_ack = 1'b0; m_halt = 1'b0;
                    end else begin
                        m_halt = h;
                    end
                end
                default: begin
                    m_halt = 1'b0;
                    if (!ch) begin
                        m_st = M_RUN; m_ack = 1'b1;
                    end
                end
            endcase
        end
        m_halted  = (m_st == M_HALTED) || (m_st == M_RESUMING);
        m_running = !m_halted;
    endtask

    task automatic step(input logic r, input logic h, input logic rs, input logic ch);
        logic [5:0] obs;
        @(negedge clock);
        reset = r; haltreq_i = h; resumereq_i = rs; core_halted_i = ch;
        model_edge(r, h, rs, ch);
        exp_q.push_back({m_halt, m_resume, m_halted, m_running, m_ack, m_unavail});
        @(posedge clock);
        #1;
        obs = {hart_halt_o, hart_resume_o, halted_o, running_o, resumeack_o, unavail_o};
        check(phase, obs, exp_q.pop_front());
        check({phase, "_onehot"}, {5'b0, halted_o ^ running_o}, 6'd1);
    endtask

    initial begin
        reset = 1'b1; haltreq_i = 1'b0; resumereq_i = 1'b0; core_halted_i = 1'b0;
        m_st = M_RUN; m_cnt = 0;
        m_halt = 1'b0; m_resume = 1'b0; m_halted = 1'b0; m_running = 1'b1;
        m_ack = 1'b0; m_unavail = 1'b0;

        phase = "reset";
        repeat (3) step(1, 1, 0, 0);
        phase = "halt_entry";
        repeat (5) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        phase = "resume";
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        phase = "timeout";
        repeat (12) step(0, 1, 0, 0);
        step(0, 1, 0, 1);

        phase = "simul_req";
        repeat (4) step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        phase = "abort";
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        phase = "unrequested";
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        phase = "mid_reset";
        repeat (2) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
